// File: rtl/cmp_iter.sv
// Iterative magnitude comparator: walks the operands S bits per cycle from
// the most significant slice down and stops at the first differing slice.
module cmp_iter #(
    parameter int N = 32,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         result,
    output logic         lt,
    output logic         eq,
    output logic         gt,
    output logic         err
);
    localparam int NS = N / S;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

    generate
        if (S < 1 || S > N || (N % S) != 0) begin : g_bad_params
            $error("cmp_iter: N must be a non-zero multiple of S");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and in_ready / out_valid are
    // pure decodes of the state register.
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_q, b_q;
    logic [2:0]     op_q;
    logic [IW-1:0]  idx;
    logic           lt_q, eq_q, gt_q;
    logic [S-1:0]   sa, sb;
    logic           accept;

    assign sa     = a_q[int'(idx)*S +: S];
    assign sb     = b_q[int'(idx)*S +: S];
    assign accept = in_valid && (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SCAN;
            SCAN:    if (sa != sb || idx == '0) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            idx   <= '0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // Flipping the sign bit maps two's-complement order onto unsigned order.
                a_q  <= is_signed ? (a ^ MSB_MASK) : a;
                b_q  <= is_signed ? (b ^ MSB_MASK) : b;
                op_q <= op;
                idx  <= IW'(NS - 1);
                lt_q <= 1'b0;
                eq_q <= 1'b0;
                gt_q <= 1'b0;
            end else if (state == SCAN) begin
                if (sa != sb) begin
                    lt_q <= (sa < sb);
                    gt_q <= (sa > sb);
                    eq_q <= 1'b0;
                end else if (idx == '0) begin
                    lt_q <= 1'b0;
                    gt_q <= 1'b0;
                    eq_q <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

    logic raw_result;

    always_comb begin
        raw_result = 1'b0;
        case (op_q)
            3'd0:    raw_result = eq_q;
            3'd1:    raw_result = !eq_q;
            3'd2:    raw_result = lt_q;
            3'd3:    raw_result = lt_q | eq_q;
            3'd4:    raw_result = gt_q;
            3'd5:    raw_result = gt_q | eq_q;
            default: raw_result = 1'b0;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = out_valid & raw_result;
    assign lt        = out_valid & lt_q;
    assign eq        = out_valid & eq_q;
    assign gt        = out_valid & gt_q;
    assign err       = out_valid & (op_q > 3'd5);

endmodule

// File: tb/tb_cmp_iter.sv
// Directed and randomized checks of cmp_iter against an arithmetic reference
// model of relation, result, error flag and latency.
module tb_cmp_iter;
    localparam int N  = 32;
    localparam int S  = 4;
    localparam int NS = N / S;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic [2:0]   op;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic         result, lt, eq, gt, err;

    int errors = 0;
    int checks = 0;

    cmp_iter #(.N(N), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: relation from plain (signed or unsigned) arithmetic,
    // latency from the position of the highest differing bit.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                         input logic [2:0] mop, input logic msgn,
                         output logic [4:0] flags, output int lat);
        logic e_lt, e_eq, e_gt, e_res, e_err;
        logic [N-1:0] diff;
        int top;
        if (msgn) begin
            e_lt = $signed(ma) < $signed(mb);
            e_gt = $signed(ma) > $signed(mb);
        end else begin
            e_lt = ma < mb;
            e_gt = ma > mb;
        end
        e_eq  = (ma == mb);
        e_err = (mop > 3'd5);
        case (mop)
            3'd0:    e_res = e_eq;
            3'd1:    e_res = !e_eq;
            3'd2:    e_res = e_lt;
            3'd3:    e_res = e_lt || e_eq;
            3'd4:    e_res = e_gt;
            3'd5:    e_res = e_gt || e_eq;
            default: e_res = 1'b0;
        endcase
        diff = ma ^ mb;
        top = -1;
        for (int i = 0; i < N; i++) if (diff[i]) top = i;
        lat = (top < 0) ? NS + 1 : 1 + (NS - top / S);
        flags = {e_res, e_lt, e_eq, e_gt, e_err};
    endtask

    task automatic run_req(input logic [N-1:0] ra, input logic [N-1:0] rb,
                           input logic [2:0] rop, input logic rsgn, input int stall);
        logic [4:0] exp_flags;
        logic [4:0] seen;
        int exp_lat;
        int lat;
        model(ra, rb, rop, rsgn, exp_flags, exp_lat);
        check("idle_in_ready", in_ready, 1'b1);
        a = ra; b = rb; op = rop; is_signed = rsgn;
        in_valid = 1'b1;
        tick();
        lat = 1;
        while (!out_valid && lat <= NS + 4) begin
            check("scan_in_ready", in_ready, 1'b0);
            check("scan_outputs_zero", {result, lt, eq, gt, err}, 5'b0);
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7)); is_signed = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        seen = {result, lt, eq, gt, err};
        check("flags_res_lt_eq_gt_err", seen, exp_flags);
        for (int k = 0; k < stall; k++) begin
            a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
            tick();
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_flags_stable", {result, lt, eq, gt, err}, exp_flags);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_take_out_valid", out_valid, 1'b0);
        check("post_take_in_ready", in_ready, 1'b1);
        check("post_take_outputs_zero", {result, lt, eq, gt, err}, 5'b0);
    endtask

    initial begin
        logic [N-1:0] ra, rb, mask;
        int sl;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; is_signed = 1'b0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_outputs_zero", {result, lt, eq, gt, err}, 5'b0);
        rst_n = 1'b1;
        tick();

        run_req(32'h0000_0005, 32'h0000_0005, 3'd0, 1'b0, 0);
        run_req(32'h8000_0000, 32'h0000_0001, 3'd2, 1'b1, 0);
        run_req(32'h8000_0000, 32'h0000_0001, 3'd2, 1'b0, 0);
        run_req(32'h0000_0010, 32'h0000_0011, 3'd5, 1'b0, 0);
        run_req(32'h1234_5678, 32'h1234_0000, 3'd4, 1'b0, 5);
        run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 1'b0, 0);
        run_req(32'hFFFF_FFFF, 32'h0000_0000, 3'd7, 1'b1, 1);

        // Reset during the third SCAN cycle, with in_valid asserted alongside it.
        a = 32'hAAAA_AAAA; b = 32'hAAAA_AAAA; op = 3'd0; is_signed = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_reset_scanning", in_ready, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("mid_reset_in_ready", in_ready, 1'b1);
        check("mid_reset_out_valid", out_valid, 1'b0);
        for (int k = 0; k < NS + 2; k++) begin
            tick();
            check("discarded_no_out_valid", out_valid, 1'b0);
        end
        run_req(32'h0000_0001, 32'h0000_0002, 3'd4, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: begin
                    sl = $urandom_range(0, NS - 1);
                    mask = N'($urandom_range(1, (1 << S) - 1)) << (sl * S);
                    rb = ra ^ mask;
                end
                default: rb = $urandom;
            endcase
            run_req(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
